// File: rtl/add_fu_issue.sv
// add_fu_issue: picks a ready ADD-class reservation entry round-robin, executes it,
// and holds the result in a single register that requests the CDB.
module add_fu_issue #(
    parameter int NUM_RS     = 3,
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 3
) (
    input  logic                         clk,
    input  logic                         flush,
    input  logic [NUM_RS-1:0]            rs_busy,
    input  logic [NUM_RS-1:0]            rs_Vj_valid,
    input  logic [NUM_RS-1:0]            rs_Vk_valid,
    input  logic [NUM_RS*DATA_WIDTH-1:0] rs_Vj,
    input  logic [NUM_RS*DATA_WIDTH-1:0] rs_Vk,
    input  logic [NUM_RS*4-1:0]          rs_op,
    input  logic [NUM_RS*TAG_WIDTH-1:0]  rs_dest,
    output logic [NUM_RS-1:0]            rs_clr_busy,
    output logic                         cdb_req,
    output logic [TAG_WIDTH-1:0]         cdb_tag,
    output logic [DATA_WIDTH-1:0]        cdb_value,
    input  logic                         cdb_grant
);
    localparam int PW = NUM_RS > 1 ? $clog2(NUM_RS) : 1;
    localparam logic [PW:0] NRS = (PW+1)'(NUM_RS);
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;
    logic [DATA_WIDTH-1:0] vj_a [NUM_RS];
    logic [DATA_WIDTH-1:0] vk_a [NUM_RS];
    logic [3:0]            op_a [NUM_RS];
    logic [TAG_WIDTH-1:0]  dest_a [NUM_RS];
    logic [NUM_RS-1:0]     ready;
    logic [PW-1:0]         rr_ptr, sel;
    logic [PW:0]           cand;
    logic                  found, slot_free, issue;
    logic [DATA_WIDTH-1:0] vj, vk, result;
    logic [3:0]            op;
    genvar i;
    for (i = 0; i < NUM_RS; i++) begin : g_unpack
        assign vj_a[i]   = rs_Vj[i*DATA_WIDTH +: DATA_WIDTH];
        assign vk_a[i]   = rs_Vk[i*DATA_WIDTH +: DATA_WIDTH];
        assign op_a[i]   = rs_op[i*4 +: 4];
        assign dest_a[i] = rs_dest[i*TAG_WIDTH +: TAG_WIDTH];
        assign ready[i]  = rs_busy[i] & rs_Vj_valid[i] & (rs_Vk_valid[i] | op_a[i] == OP_NOT);
    end
    // Scan starts at rr_ptr and wraps, so the last-issued entry gets lowest priority.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_RS; k++) begin
            cand = {1'b0, rr_ptr} + (PW+1)'(k);
            cand = cand >= NRS ? cand - NRS : cand;
            if (!found && ready[cand[PW-1:0]]) begin
                found = 1'b1;
                sel   = cand[PW-1:0];
            end
        end
    end
    assign vj = vj_a[sel];
    assign vk = vk_a[sel];
    assign op = op_a[sel];
    assign result = op == OP_ADD ? vj + vk :
                    op == OP_AND ? vj & vk :
                    op == OP_NOT ? ~vj : '0;
    assign slot_free   = !cdb_req | cdb_grant;
    assign issue       = slot_free & found & !flush;
    assign rs_clr_busy = issue ? (NUM_RS'(1) << sel) : '0;
    always_ff @(posedge clk) begin
        if (flush) begin
            cdb_req   <= 1'b0;
            cdb_tag   <= '0;
            cdb_value <= '0;
            rr_ptr    <= '0;
        end else if (issue) begin
            cdb_req   <= 1'b1;
            cdb_tag   <= dest_a[sel];
            cdb_value <= result;
            rr_ptr    <= sel == PW'(NUM_RS-1) ? '0 : sel + 1'b1;
        end else if (cdb_grant) begin
            cdb_req <= 1'b0;
        end
    end
endmodule
